// File: rtl/clock_pkg.sv
// Shared types for the clock monitor.
//   clkmon_state_t : monitor FSM state encoding
//   MinSyncStages  : lower bound on synchronizer depth
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        LOST    = 2'd3
    } clkmon_state_t;

    localparam int unsigned MinSyncStages = 2;

endpackage : clock_pkg

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous bit.
//   clk : destination clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input
//   q   : synchronized output (last stage)
module sync_ff #(
    parameter int unsigned Stages = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [Stages-1:0] chain;

    // Shift chain; stage 0 is the metastability-catching flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[Stages-2:0], d};
        end
    end

    assign q = chain[Stages-1];

endmodule : sync_ff

// File: rtl/clock_monitor.sv
// Measures period and high time of a slow asynchronous clock and flags
// lock (stable period) and loss (no rising edge for MaxPeriod cycles).
//   clk, rst  : system clock, synchronous active-high reset
//   clk_in    : monitored asynchronous clock
//   edge_pos  : one-cycle strobe per detected rising edge of clk_in
//   edge_neg  : one-cycle strobe per detected falling edge of clk_in
//   period    : clk cycles between the last two rising edges
//   high_time : clk cycles from the last rising edge to the next falling edge
//   locked    : period stable within Tolerance
//   lost      : no rising edge seen for MaxPeriod cycles
module clock_monitor
    import clock_pkg::*;
#(
    parameter  int unsigned MaxPeriod  = 256,
    parameter  int unsigned Tolerance  = 1,
    parameter  int unsigned SyncStages = 2,
    localparam int unsigned W          = $clog2(MaxPeriod + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_in,
    output logic         edge_pos,
    output logic         edge_neg,
    output logic [W-1:0] period,
    output logic [W-1:0] high_time,
    output logic         locked,
    output logic         lost
);

    // Depth is clamped so a misconfigured instance still synchronizes safely.
    localparam int unsigned Stages = (SyncStages < MinSyncStages) ? MinSyncStages : SyncStages;

    logic          s;
    logic          s_d;
    logic          rise;
    logic          fall;
    logic [W-1:0]  cnt;
    logic [W:0]    diff;
    logic [W:0]    abs_diff;
    logic          in_tol;
    logic          timeout;
    logic          locked_nxt;
    logic          lost_nxt;
    clkmon_state_t state;
    clkmon_state_t next_state;

    sync_ff #(
        .Stages(Stages)
    ) u_sync (
        .clk(clk),
        .rst(rst),
        .d  (clk_in),
        .q  (s)
    );

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // One extra bit keeps the difference of two W-bit counts from wrapping.
    assign diff     = {1'b0, cnt} - {1'b0, period};
    assign abs_diff = diff[W] ? (W+1)'(-diff) : diff;
    assign in_tol   = (abs_diff <= (W+1)'(Tolerance));

    // A rise in the timeout cycle wins.
    assign timeout  = (cnt == W'(MaxPeriod)) && !rise;

    // Edge detect delay, strobes and measurement datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_d       <= 1'b0;
            edge_pos  <= 1'b0;
            edge_neg  <= 1'b0;
            cnt       <= '0;
            period    <= '0;
            high_time <= '0;
        end else begin
            s_d      <= s;
            edge_pos <= rise;
            edge_neg <= fall;
            if (rise) begin
                cnt <= W'(1);
            end else if (cnt != W'(MaxPeriod)) begin
                cnt <= cnt + W'(1);
            end
            if (rise && (state != IDLE)) begin
                period <= cnt;
            end
            if (fall && ((state == MEASURE) || (state == LOCKED))) begin
                high_time <= cnt;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (rise) next_state = MEASURE;
            end
            MEASURE: begin
                if (rise) begin
                    if (cnt >= W'(2)) next_state = LOCKED;
                end else if (timeout) begin
                    next_state = LOST;
                end
            end
            LOCKED: begin
                if (rise) begin
                    if (!in_tol) next_state = MEASURE;
                end else if (timeout) begin
                    next_state = LOST;
                end
            end
            LOST: begin
                if (rise) next_state = MEASURE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Output decode; registered below so flags track the state register exactly.
    always_comb begin
        locked_nxt = 1'b0;
        lost_nxt   = 1'b0;
        locked_nxt = (next_state == LOCKED);
        lost_nxt   = (next_state == LOST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            locked <= 1'b0;
            lost   <= 1'b0;
        end else begin
            locked <= locked_nxt;
            lost   <= lost_nxt;
        end
    end

endmodule : clock_monitor

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor: expected edge results are queued when
// clk_in is driven and checked when the strobes appear.
module tb_clock_monitor;

    localparam int unsigned MaxPeriod  = 16;
    localparam int unsigned Tolerance  = 1;
    localparam int unsigned SyncStages = 2;
    localparam int unsigned W          = $clog2(MaxPeriod + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic         clk_in;
    logic         edge_pos;
    logic         edge_neg;
    logic [W-1:0] period;
    logic [W-1:0] high_time;
    logic         locked;
    logic         lost;

    typedef struct {
        logic [W-1:0] period;
        logic         locked;
        logic         lost;
    } rise_exp_t;

    rise_exp_t rise_q[$];
    int        fall_q[$];

    int checks        = 0;
    int fails         = 0;
    int cyc           = 0;
    int last_rise_cyc = 0;

    clock_monitor #(
        .MaxPeriod (MaxPeriod),
        .Tolerance (Tolerance),
        .SyncStages(SyncStages)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clk_in   (clk_in),
        .edge_pos (edge_pos),
        .edge_neg (edge_neg),
        .period   (period),
        .high_time(high_time),
        .locked   (locked),
        .lost     (lost)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: compare queued expectations at each strobe.
    always @(posedge clk) begin
        rise_exp_t e;
        int        h;
        #1;
        if (edge_pos === 1'b1) begin
            last_rise_cyc = cyc;
            if (rise_q.size() == 0) begin
                chk("unexpected_edge_pos", 32'd1, 32'd0);
            end else begin
                e = rise_q.pop_front();
                chk("rise_period", 32'(period), 32'(e.period));
                chk("rise_locked", 32'(locked), 32'(e.locked));
                chk("rise_lost", 32'(lost), 32'(e.lost));
            end
        end
        if (edge_neg === 1'b1) begin
            if (fall_q.size() == 0) begin
                chk("unexpected_edge_neg", 32'd1, 32'd0);
            end else begin
                h = fall_q.pop_front();
                chk("fall_high_time", 32'(high_time), 32'(h));
            end
        end
    end

    // Drive one clk_in cycle starting at a negedge; the rise closes the
    // previous period, giving the expected period/locked after it.
    task automatic pulse(input int hi, input int lo, input int ep, input logic el);
        rise_exp_t e;
        e.period = W'(ep);
        e.locked = el;
        e.lost   = 1'b0;
        clk_in = 1'b1;
        rise_q.push_back(e);
        repeat (hi) @(negedge clk);
        clk_in = 1'b0;
        fall_q.push_back(hi);
        repeat (lo) @(negedge clk);
    endtask

    task automatic push_rise(input int ep, input logic el);
        rise_exp_t e;
        e.period = W'(ep);
        e.locked = el;
        e.lost   = 1'b0;
        rise_q.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_edge_pos"}, 32'(edge_pos), 32'd0);
        chk({tag, "_edge_neg"}, 32'(edge_neg), 32'd0);
        chk({tag, "_period"}, 32'(period), 32'd0);
        chk({tag, "_high_time"}, 32'(high_time), 32'd0);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_lost"}, 32'(lost), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst    = 1'b1;
        clk_in = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Dead clock after reset stays in IDLE, never lost.
        repeat (20) @(negedge clk);
        chk("dead_lost", 32'(lost), 32'd0);
        chk("dead_locked", 32'(locked), 32'd0);
        chk("dead_period", 32'(period), 32'd0);

        // 2 high / 2 low: first rise only arms, second locks at 4.
        pulse(2, 2, 0, 1'b0);
        pulse(2, 2, 4, 1'b1);
        pulse(2, 2, 4, 1'b1);
        pulse(2, 2, 4, 1'b1);

        // Hold low: lost must rise exactly MaxPeriod cycles after the last rise.
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (lost === 1'b1) seen = 1'b1;
        end
        chk("loss_seen", 32'(seen), 32'd1);
        chk("loss_latency", 32'(cyc - last_rise_cyc), 32'(MaxPeriod));
        chk("loss_locked", 32'(locked), 32'd0);
        @(negedge clk);

        // Recovery rise records the saturated count, then 3 high / 2 low.
        pulse(3, 2, 16, 1'b0);
        pulse(3, 2, 5, 1'b1);
        pulse(3, 2, 5, 1'b1);

        // Period 5 -> 8 drops lock, relock at 8, then tolerance probes.
        pulse(4, 4, 5, 1'b1);
        pulse(4, 4, 8, 1'b0);
        pulse(4, 4, 8, 1'b1);
        pulse(4, 5, 8, 1'b1);
        pulse(4, 8, 9, 1'b1);
        pulse(4, 8, 12, 1'b0);
        pulse(4, 8, 12, 1'b1);

        // Reset mid-high while locked.
        clk_in = 1'b1;
        push_rise(12, 1'b1);
        repeat (3) @(negedge clk);
        chk("prereset_locked", 32'(locked), 32'd1);
        chk("prereset_period", 32'(period), 32'd12);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        rst = 1'b0;
        push_rise(0, 1'b0);
        repeat (4) @(negedge clk);
        clk_in = 1'b0;
        fall_q.push_back(4);
        repeat (4) @(negedge clk);
        clk_in = 1'b1;
        push_rise(8, 1'b1);
        repeat (4) @(negedge clk);
        clk_in = 1'b0;
        fall_q.push_back(4);
        repeat (8) @(negedge clk);

        chk("rise_queue_drained", 32'(rise_q.size()), 32'd0);
        chk("fall_queue_drained", 32'(fall_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule : tb_clock_monitor
